// File: rtl/memory_requester.sv
// memory_requester: single-outstanding req/resp front end for the level-sensitive cached `memory` block.
// Latency: repeated read 1 cycle, cache hit 3 cycles, repeated write hit 5 cycles, miss follows mem_valid.
// Backpressure: req_ready only in IDLE; optional watchdog under `define MEM_REQ_TIMEOUT_EN.
module memory_requester #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_wren,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    input  logic              mem_valid
);

    typedef enum logic [1:0] {DRAIN, IDLE, SETTLE, WAIT} state_t;

    state_t              state, nxt_state;
    logic [ADDR_W-1:0]   nxt_mem_address;
    logic [DATA_W-1:0]   nxt_mem_data;
    logic                nxt_mem_wren;
    logic                nxt_resp_valid;
    logic [DATA_W-1:0]   nxt_resp_data;
    logic                last_ok, nxt_last_ok;
    logic [ADDR_W-1:0]   last_addr, nxt_last_addr;
    logic                last_wren, nxt_last_wren;
    logic                pend_wr, nxt_pend_wr;
    logic [ADDR_W-1:0]   lat_addr, nxt_lat_addr;
    logic                lat_wren, nxt_lat_wren;
    logic [DATA_W-1:0]   lat_wdata, nxt_lat_wdata;
    // One-deep history of mem_valid while draining; two valid samples in a row mean memory is quiescent.
    logic                drain_seen, nxt_drain_seen;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0]     wd_cnt, nxt_wd_cnt;
    logic                nxt_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    // Next-state and next-register computation; everything holds unless a transition changes it.
    always_comb begin
        nxt_state       = state;
        nxt_mem_address = mem_address;
        nxt_mem_data    = mem_data;
        nxt_mem_wren    = mem_wren;
        nxt_resp_valid  = 1'b0;
        nxt_resp_data   = resp_data;
        nxt_last_ok     = last_ok;
        nxt_last_addr   = last_addr;
        nxt_last_wren   = last_wren;
        nxt_pend_wr     = pend_wr;
        nxt_lat_addr    = lat_addr;
        nxt_lat_wren    = lat_wren;
        nxt_lat_wdata   = lat_wdata;
        nxt_drain_seen  = drain_seen;
`ifdef MEM_REQ_TIMEOUT_EN
        nxt_wd_cnt      = wd_cnt;
        nxt_resp_err    = resp_err;
`endif
        case (state)
            DRAIN: begin
                nxt_drain_seen = mem_valid;
                if (mem_valid && drain_seen) begin
                    nxt_last_addr  = '0;
                    nxt_last_wren  = 1'b0;
                    nxt_last_ok    = 1'b1;
                    nxt_drain_seen = 1'b0;
                    nxt_state      = IDLE;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    nxt_lat_addr  = req_addr;
                    nxt_lat_wren  = req_wren;
                    nxt_lat_wdata = req_wdata;
                    if (last_ok && (req_addr == last_addr) && !req_wren && !last_wren) begin
                        // Memory already presents this read; answer from q without a new access.
                        nxt_resp_data  = mem_q;
                        nxt_resp_valid = 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
                        nxt_resp_err   = 1'b0;
`endif
                    end else if (last_ok && (req_addr == last_addr) && req_wren && last_wren) begin
                        // An identical write would be invisible to memory; toggle through a read first.
                        nxt_mem_address = req_addr;
                        nxt_mem_wren    = 1'b0;
                        nxt_pend_wr     = 1'b1;
                        nxt_state       = SETTLE;
                    end else begin
                        nxt_mem_address = req_addr;
                        nxt_mem_wren    = req_wren;
                        nxt_mem_data    = req_wdata;
                        nxt_state       = SETTLE;
                    end
                end
            end
            SETTLE: begin
                // mem_valid is stale here: memory has only just sampled the new request.
                nxt_state = WAIT;
`ifdef MEM_REQ_TIMEOUT_EN
                nxt_wd_cnt = '0;
`endif
            end
            WAIT: begin
                if (mem_valid) begin
                    if (pend_wr) begin
                        nxt_mem_address = lat_addr;
                        nxt_mem_wren    = 1'b1;
                        nxt_mem_data    = lat_wdata;
                        nxt_pend_wr     = 1'b0;
                        nxt_state       = SETTLE;
                    end else begin
                        nxt_resp_data  = mem_q;
                        nxt_resp_valid = 1'b1;
                        nxt_last_addr  = lat_addr;
                        nxt_last_wren  = lat_wren;
                        nxt_last_ok    = 1'b1;
                        nxt_state      = IDLE;
`ifdef MEM_REQ_TIMEOUT_EN
                        nxt_resp_err   = 1'b0;
`endif
                    end
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (wd_cnt == WD_LAST) begin
                    nxt_wd_cnt      = WD_MAX;
                    nxt_resp_valid  = 1'b1;
                    nxt_resp_err    = 1'b1;
                    nxt_resp_data   = '0;
                    nxt_last_ok     = 1'b0;
                    nxt_pend_wr     = 1'b0;
                    nxt_mem_address = '0;
                    nxt_mem_wren    = 1'b0;
                    nxt_mem_data    = '0;
                    nxt_drain_seen  = 1'b0;
                    nxt_state       = DRAIN;
                end else if (wd_cnt != WD_MAX) begin
                    nxt_wd_cnt = wd_cnt + 1'b1;
                end
`endif
            end
            default: nxt_state = DRAIN;
        endcase
    end

    // State and datapath registers; reset abandons any access and parks memory on a read of address 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= DRAIN;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            resp_valid  <= 1'b0;
            resp_data   <= '0;
            last_ok     <= 1'b0;
            last_addr   <= '0;
            last_wren   <= 1'b0;
            pend_wr     <= 1'b0;
            lat_addr    <= '0;
            lat_wren    <= 1'b0;
            lat_wdata   <= '0;
            drain_seen  <= 1'b0;
        end else begin
            state       <= nxt_state;
            mem_address <= nxt_mem_address;
            mem_data    <= nxt_mem_data;
            mem_wren    <= nxt_mem_wren;
            resp_valid  <= nxt_resp_valid;
            resp_data   <= nxt_resp_data;
            last_ok     <= nxt_last_ok;
            last_addr   <= nxt_last_addr;
            last_wren   <= nxt_last_wren;
            pend_wr     <= nxt_pend_wr;
            lat_addr    <= nxt_lat_addr;
            lat_wren    <= nxt_lat_wren;
            lat_wdata   <= nxt_lat_wdata;
            drain_seen  <= nxt_drain_seen;
        end
    end

`ifdef MEM_REQ_TIMEOUT_EN
    // Watchdog counter and error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt   <= '0;
            resp_err <= 1'b0;
        end else begin
            wd_cnt   <= nxt_wd_cnt;
            resp_err <= nxt_resp_err;
        end
    end
`endif

endmodule

// File: tb/tb_memory_requester.sv
// tb_memory_requester: directed stimulus against a small cached-memory model, scoreboard checks responses.
// Latency: expected response cycle is pushed with each request and compared by the monitor.
// Backpressure: driver waits (bounded) on req_ready before presenting each request.
module tb_memory_requester;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_addr;
    logic       req_wren;
    logic [7:0] req_wdata;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       resp_err;
    logic [4:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic [7:0] m_q;
    logic       mem_valid;

    memory_requester #(.ADDR_W(5), .DATA_W(8), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wren(req_wren), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(m_q), .mem_valid(mem_valid)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    // Addresses 0x1E/0x1F are non-resident (miss), all others hit.
    // Initial contents: store[a] = 0x40 + a.
    logic [7:0] store [32];
    bit         m_init;
    bit         m_busy;
    int         m_cnt;
    logic [4:0] cur_a = '0;
    logic       cur_w = 1'b0;
    int         miss_lat = 5;
    logic       force_low;

    function automatic bit resident(input logic [4:0] a);
        return !(a == 5'h1F || a == 5'h1E);
    endfunction

    assign mem_valid = !m_busy && !force_low;

    always @(posedge clock) begin
        if (!m_init) begin
            for (int i = 0; i < 32; i++) store[i] <= 8'(8'h40 + i);
            m_q    <= 8'h00;
            m_init <= 1'b1;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_busy <= 1'b0;
                if (cur_w) begin
                    store[cur_a] <= mem_data;
                    m_q          <= mem_data;
                end else begin
                    m_q <= store[cur_a];
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (mem_address != cur_a || mem_wren != cur_w) begin
            cur_a <= mem_address;
            cur_w <= mem_wren;
            if (resident(mem_address)) begin
                if (mem_wren) begin
                    store[mem_address] <= mem_data;
                    m_q                <= mem_data;
                end else begin
                    m_q <= store[mem_address];
                end
            end else begin
                m_busy <= 1'b1;
                m_cnt  <= miss_lat;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] d;
        logic       e;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every resp_valid pulse pops one expectation.
    always @(negedge clock) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_data), 32'hFFFF_FFFF);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                chk("resp_data", 32'(resp_data), 32'(x.d));
                chk("resp_err", 32'(resp_err), 32'(x.e));
                if (x.at >= 0) chk("resp_cycle", 32'(cyc), 32'(x.at));
            end
        end
    end

    // Called at a negedge; lat = edges after acceptance edge (-1 = unbounded).
    task automatic issue(input logic [4:0] a, input logic w, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee, input int lat);
        int b;
        exp_t x;
        b = 0;
        while (!req_ready && b < 100) begin
            @(negedge clock);
            b++;
        end
        if (b >= 100) chk("req_ready_wait", 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wren  = w;
        req_wdata = d;
        x.d  = ed;
        x.e  = ee;
        x.at = (lat < 0) ? -1 : cyc + 1 + lat;
        exp_q.push_back(x);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || !req_ready) && b < 200) begin
            @(negedge clock);
            b++;
        end
        chk("pending_responses", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  saw_dummy;
        logic [4:0] a_before;
        logic       w_before;

        reset     = 1'b1;
        force_low = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wren  = 1'b0;
        req_wdata = '0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_mem_address", 32'(mem_address), 32'h0);
        chk("rst_mem_wren", 32'(mem_wren), 32'h0);
        chk("rst_mem_data", 32'(mem_data), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        reset = 1'b0;

        // DRAIN holds while memory is not valid, then needs two valid samples
        repeat (3) @(negedge clock);
        chk("drain_hold_ready", 32'(req_ready), 32'h0);
        force_low = 1'b0;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("drain_cycles", 32'(n), 32'd2);

        // Write 0x5A @3 (hit), read back @3 (hit)
        issue(5'h03, 1'b1, 8'h5A, 8'h5A, 1'b0, 2);
        wait_done();
        issue(5'h03, 1'b0, 8'h00, 8'h5A, 1'b0, 2);
        wait_done();

        // Two repeated reads back-to-back: answered from q, memory untouched
        a_before = mem_address;
        w_before = mem_wren;
        issue(5'h03, 1'b0, 8'h00, 8'h5A, 1'b0, 0);
        issue(5'h03, 1'b0, 8'h00, 8'h5A, 1'b0, 0);
        wait_done();
        chk("rep_rd_addr_stable", 32'(mem_address), 32'(a_before));
        chk("rep_rd_wren_stable", 32'(mem_wren), 32'(w_before));

        // Write 0x11 then 0x22 @7: second goes through a dummy read
        issue(5'h07, 1'b1, 8'h11, 8'h11, 1'b0, 2);
        wait_done();
        issue(5'h07, 1'b1, 8'h22, 8'h22, 1'b0, 4);
        saw_dummy = (mem_wren == 1'b0 && mem_address == 5'h07);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clock);
            if (exp_q.size() != 0 && mem_wren == 1'b0 && mem_address == 5'h07) saw_dummy = 1'b1;
            n++;
        end
        chk("dummy_read_seen", 32'(saw_dummy), 32'h1);
        wait_done();
        issue(5'h07, 1'b0, 8'h00, 8'h22, 1'b0, 2);
        wait_done();

        // Miss on 0x1F: contents 0x40+0x1F = 0x5F
        miss_lat = 5;
        issue(5'h1F, 1'b0, 8'h00, 8'h5F, 1'b0, -1);
        @(negedge clock);
        chk("miss_ready_low", 32'(req_ready), 32'h0);
        chk("miss_valid_low", 32'(mem_valid), 32'h0);
        wait_done();

        // Reset during WAIT on a miss: no response, DRAIN re-entered
        miss_lat = 8;
        req_valid = 1'b0;
        begin
            int b;
            b = 0;
            while (!req_ready && b < 50) begin
                @(negedge clock);
                b++;
            end
        end
        req_valid = 1'b1;
        req_addr  = 5'h1E;
        req_wren  = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_mem_address", 32'(mem_address), 32'h0);
        chk("midrst_mem_wren", 32'(mem_wren), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_drain_ready", 32'(req_ready), 32'h0);
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("midrst_recovered", 32'(req_ready), 32'h1);
        issue(5'h03, 1'b0, 8'h00, 8'h5A, 1'b0, 2);
        wait_done();

`ifdef MEM_REQ_TIMEOUT_EN
        // Watchdog: memory never valid, error after 4 WAIT cycles
        force_low = 1'b1;
        issue(5'h05, 1'b0, 8'h00, 8'h00, 1'b1, 5);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("timeout_to_drain", 32'(req_ready), 32'h0);
        force_low = 1'b0;
        wait_done();
`endif

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
